// File: rtl/dffers_pipe.sv
// rtl/dffers_pipe.sv - WIDTH x DEPTH elastic register pipeline with enable, set/flush and async reset
// Each stage advances when the next stage is empty or itself advancing.
module dffers_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
  input  logic                       clk,
  input  logic                       R,
  input  logic                       S,
  input  logic                       E,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           D,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           Q,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] mv, ld;
  logic [CW-1:0]    count_q, count_d;
  logic             go, accept, emit;

  // Move chain resolves from the output end back toward stage 0.
  always_comb begin
    go = E & S & R;
    mv = '0;
    mv[DEPTH-1] = go & v_q[DEPTH-1] & out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      mv[i] = go & v_q[i] & (~v_q[i+1] | mv[i+1]);
    end
    in_ready = go & (~v_q[0] | mv[0]);
    accept   = in_valid & in_ready;
    emit     = mv[DEPTH-1];
  end

  always_comb begin
    ld     = '0;
    ld[0]  = accept;
    for (int i = 1; i < DEPTH; i++) begin
      ld[i] = mv[i-1];
    end
    v_d = ld | (v_q & ~mv);
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    if (accept) data_d[0] = D;
    for (int i = 1; i < DEPTH; i++) begin
      if (ld[i]) data_d[i] = data_q[i-1];
    end
    case ({accept, emit})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Flush wins over enable and handshake.
    if (!S) begin
      v_d     = '0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = SET_VAL;
      end
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign Q         = data_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_dffers_pipe.sv
// tb/tb_dffers_pipe.sv - bench for dffers_pipe at DEPTH=4 and DEPTH=1
// Model: ordered list of in-flight words with stage positions.
module tb_dffers_pipe;

  logic       clk = 1'b0;
  logic       r_n, s_n, e;
  logic       a_iv, a_ir, a_ov, a_or;
  logic [7:0] a_d, a_q;
  logic [2:0] a_cnt;
  logic       b_iv, b_ir, b_ov, b_or;
  logic [7:0] b_d, b_q;
  logic [0:0] b_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  dffers_pipe #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk(clk), .R(r_n), .S(s_n), .E(e),
    .in_valid(a_iv), .in_ready(a_ir), .D(a_d),
    .out_valid(a_ov), .out_ready(a_or), .Q(a_q), .count(a_cnt)
  );

  dffers_pipe #(.WIDTH(8), .DEPTH(1)) dut_b (
    .clk(clk), .R(r_n), .S(s_n), .E(e),
    .in_valid(b_iv), .in_ready(b_ir), .D(b_d),
    .out_valid(b_ov), .out_ready(b_or), .Q(b_q), .count(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  int         mn [2];
  logic [7:0] md [2][4];
  int         mp [2][4];
  logic [7:0] mq [2];

  function automatic int dep(input int id);
    return (id == 0) ? 4 : 1;
  endfunction

  // Position of the newest word after this cycle's moves, -1 when none remain.
  function automatic int last_pos_after(input int id, input logic ordy);
    int lim, k0, np;
    lim = dep(id) - 1;
    k0  = 0;
    np  = -1;
    if (mn[id] > 0 && mp[id][0] == dep(id) - 1 && ordy) k0 = 1;
    for (int k = k0; k < mn[id]; k++) begin
      np  = (mp[id][k] + 1 < lim) ? mp[id][k] + 1 : lim;
      lim = np - 1;
    end
    return np;
  endfunction

  function automatic logic exp_ir(input int id, input logic ordy);
    if (!(e && s_n && r_n)) return 1'b0;
    return last_pos_after(id, ordy) != 0;
  endfunction

  function automatic logic exp_ov(input int id);
    return mn[id] > 0 && mp[id][0] == dep(id) - 1;
  endfunction

  task automatic model_step(input int id, input logic iv, input logic [7:0] d, input logic ordy);
    int lim, np;
    if (!s_n) begin
      mn[id] = 0;
      mq[id] = 8'hFF;
      return;
    end
    if (!e) return;
    if (mn[id] > 0 && mp[id][0] == dep(id) - 1 && ordy) begin
      for (int k = 0; k < mn[id] - 1; k++) begin
        md[id][k] = md[id][k+1];
        mp[id][k] = mp[id][k+1];
      end
      mn[id]--;
    end
    lim = dep(id) - 1;
    for (int k = 0; k < mn[id]; k++) begin
      np = (mp[id][k] + 1 < lim) ? mp[id][k] + 1 : lim;
      if (np == dep(id) - 1 && mp[id][k] != dep(id) - 1) mq[id] = md[id][k];
      mp[id][k] = np;
      lim = np - 1;
    end
    if (iv && (mn[id] == 0 || mp[id][mn[id]-1] > 0)) begin
      md[id][mn[id]] = d;
      mp[id][mn[id]] = 0;
      if (dep(id) == 1) mq[id] = d;
      mn[id]++;
    end
  endtask

  always @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      for (int id = 0; id < 2; id++) begin
        mn[id] = 0;
        mq[id] = 8'h00;
      end
    end else begin
      model_step(0, a_iv, a_d, a_or);
      model_step(1, b_iv, b_d, b_or);
    end
  end

  always @(negedge clk) begin
    chk("a.q",        32'(a_q),   32'(mq[0]));
    chk("a.out_valid", 32'(a_ov), 32'(exp_ov(0)));
    chk("a.count",    32'(a_cnt), 32'(mn[0]));
    chk("a.in_ready", 32'(a_ir),  32'(exp_ir(0, a_or)));
    chk("b.q",        32'(b_q),   32'(mq[1]));
    chk("b.out_valid", 32'(b_ov), 32'(exp_ov(1)));
    chk("b.count",    32'(b_cnt), 32'(mn[1]));
    chk("b.in_ready", 32'(b_ir),  32'(exp_ir(1, b_or)));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    r_n = 1'b0; s_n = 1'b1; e = 1'b1;
    a_iv = 1'b0; a_d = 8'h00; a_or = 1'b0;
    b_iv = 1'b0; b_d = 8'h00; b_or = 1'b0;
    #2;
    chk("rst.q", 32'(a_q), 0);
    chk("rst.in_ready", 32'(a_ir), 0);
    cyc(); cyc();
    r_n = 1'b1;

    // Streaming at full rate
    a_or = 1'b1; a_iv = 1'b1; a_d = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 4) begin
        chk("stream.q4", 32'(a_q), 'h01);
        chk("stream.ov4", 32'(a_ov), 1);
        chk("stream.cnt4", 32'(a_cnt), 4);
      end
      if (k == 8) begin
        chk("stream.q8", 32'(a_q), 'h05);
        chk("stream.cnt8", 32'(a_cnt), 4);
      end
      a_d = 8'(k + 1);
    end
    a_iv = 1'b0;
    repeat (6) cyc();
    chk("drain.cnt", 32'(a_cnt), 0);
    chk("drain.ov", 32'(a_ov), 0);

    // Enable freeze mid-stream
    a_iv = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a_d = 8'(8'h41 + k);
      cyc();
    end
    a_d = 8'h46;
    e = 1'b0;
    repeat (3) begin
      cyc();
      chk("freeze.in_ready", 32'(a_ir), 0);
      chk("freeze.q", 32'(a_q), 'h42);
      chk("freeze.cnt", 32'(a_cnt), 4);
    end
    e = 1'b1;
    cyc();
    chk("resume.q", 32'(a_q), 'h43);
    a_d = 8'h47;
    cyc();
    a_iv = 1'b0;
    repeat (6) cyc();

    // Backpressure until full, then release
    a_or = 1'b0; a_iv = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      a_d = 8'(k);
      cyc();
    end
    a_d = 8'h05;
    #1;
    chk("bp.cnt", 32'(a_cnt), 4);
    chk("bp.in_ready", 32'(a_ir), 0);
    repeat (2) cyc();
    chk("bp.hold.cnt", 32'(a_cnt), 4);
    a_or = 1'b1;
    #1;
    chk("bp.full_in_ready", 32'(a_ir), 1);
    for (int k = 1; k <= 5; k++) begin
      chk("bp.q", 32'(a_q), 32'(k));
      chk("bp.ov", 32'(a_ov), 1);
      cyc();
      a_iv = 1'b0;
    end
    repeat (3) cyc();
    chk("bp.empty", 32'(a_cnt), 0);

    // Set/flush with words in flight
    a_iv = 1'b1; a_d = 8'h61;
    cyc();
    a_d = 8'h62;
    cyc();
    s_n = 1'b0; a_d = 8'h63;
    cyc();
    chk("flush.q", 32'(a_q), 'hFF);
    chk("flush.ov", 32'(a_ov), 0);
    chk("flush.cnt", 32'(a_cnt), 0);
    chk("flush.in_ready_low", 32'(a_ir), 0);
    s_n = 1'b1;
    #1;
    chk("flush.in_ready", 32'(a_ir), 1);
    a_iv = 1'b0;
    cyc();

    // Asynchronous reset mid-cycle with 3 words in flight
    a_or = 1'b0; a_iv = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      a_d = 8'(8'h70 + k);
      cyc();
    end
    a_iv = 1'b0;
    cyc(); cyc();
    chk("prereset.q", 32'(a_q), 'h71);
    #2 r_n = 1'b0;
    #1;
    chk("areset.q", 32'(a_q), 0);
    chk("areset.ov", 32'(a_ov), 0);
    chk("areset.cnt", 32'(a_cnt), 0);
    cyc();
    r_n = 1'b1;

    // DEPTH=1: accept and emit together when full
    b_or = 1'b0; b_iv = 1'b1; b_d = 8'h11;
    cyc();
    chk("d1.q", 32'(b_q), 'h11);
    chk("d1.cnt", 32'(b_cnt), 1);
    b_d = 8'h22; b_or = 1'b1;
    #1;
    chk("d1.in_ready", 32'(b_ir), 1);
    cyc();
    chk("d1.q2", 32'(b_q), 'h22);
    chk("d1.cnt2", 32'(b_cnt), 1);
    chk("d1.ov2", 32'(b_ov), 1);
    b_iv = 1'b0;
    cyc();
    chk("d1.empty", 32'(b_cnt), 0);
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
